// File: rtl/tpu_sched_pkg.sv
// Shared types and sizing helpers for the TPU job scheduler.
// Holds the arbiter FSM encoding, default parameters and the counter width function.
package tpu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ        = 32'sd4;
  localparam int DEF_TIMEOUT_CYCLES = 32'sd1023;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < value) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// wrapping modulo NUM_REQ, and reports the first active requester.
module rr_arbiter #(
  parameter int NUM_REQ = 32'sd4,
  parameter int IDX_W   = 32'sd2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Priority scan; the first hit freezes the winner for the rest of the loop.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s  = {1'b0, last_grant} + (IDX_W + 1)'(i);
      cand_s = (sum_s >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum_s - (IDX_W + 1)'(NUM_REQ))
                                                : IDX_W'(sum_s);
      hit_s  = ~valid & req[cand_s];
      winner = hit_s ? cand_s : winner;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/tpu_job_arbiter.sv
// Shares one systolic array controller among NUM_REQ requesters: round-robin
// job grant, start pulse, BUSY watchdog with abort, and a completion handshake.
module tpu_job_arbiter
  import tpu_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               ack_err,
  output logic [NUM_REQ-1:0] grant,
  output logic               tpu_start,
  output logic               tpu_abort,
  input  logic               tpu_done,
  output logic               busy,
  output logic [15:0]        job_count
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'sd1);

  state_e           state_r, state_s;
  logic [IDX_W-1:0] grant_idx_r, grant_idx_s;
  logic [IDX_W-1:0] last_grant_r, last_grant_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             err_r, err_s;
  logic [15:0]      job_count_r, job_count_s;

  logic             arb_valid_s;
  logic [IDX_W-1:0] arb_winner_s;
  logic             timeout_s;
  logic [NUM_REQ-1:0] onehot_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_r),
    .valid      (arb_valid_s),
    .winner     (arb_winner_s)
  );

  assign timeout_s = (cnt_r == CNT_LAST);
  assign onehot_s  = {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant_idx_r;
  assign job_count = job_count_r;

  // State and job registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r      <= ST_IDLE;
      grant_idx_r  <= '0;
      last_grant_r <= LAST_INIT;
      cnt_r        <= '0;
      err_r        <= 1'b0;
      job_count_r  <= 16'h0000;
    end else begin
      state_r      <= state_s;
      grant_idx_r  <= grant_idx_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      err_r        <= err_s;
      job_count_r  <= job_count_s;
    end
  end

  // Next-state logic; done beats a timeout landing in the same BUSY cycle.
  always_comb begin
    state_s      = state_r;
    grant_idx_s  = grant_idx_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    err_s        = err_r;
    job_count_s  = job_count_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_idx_s = arb_winner_s;
          state_s     = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_s   = '0;
        err_s   = 1'b0;
        state_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (tpu_done) begin
          err_s   = 1'b0;
          state_s = ST_RESP;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_RESP: begin
        last_grant_s = grant_idx_r;
        if (!err_r && (job_count_r != 16'hFFFF)) begin
          job_count_s = job_count_r + 16'd1;
        end else begin
          job_count_s = job_count_r;
        end
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; forced quiet while srst is asserted.
  always_comb begin
    ack       = '0;
    ack_err   = 1'b0;
    grant     = '0;
    tpu_start = 1'b0;
    tpu_abort = 1'b0;
    busy      = 1'b0;
    if (srst) begin
      busy = 1'b0;
    end else begin
      busy = (state_r != ST_IDLE);
      case (state_r)
        ST_START: begin
          tpu_start = 1'b1;
          grant     = onehot_s;
        end
        ST_BUSY: begin
          grant     = onehot_s;
          tpu_abort = timeout_s & ~tpu_done;
        end
        ST_RESP: begin
          ack     = onehot_s;
          ack_err = err_r;
        end
        default: begin
          ack = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_arbiter.sv
// Self-checking bench: job-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_tpu_job_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       srst;
  logic [3:0] req;
  logic       tpu_done;
  logic [3:0] ack;
  logic       ack_err;
  logic [3:0] grant;
  logic       tpu_start;
  logic       tpu_abort;
  logic       busy;
  logic [15:0] job_count;

  tpu_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .srst      (srst),
    .req       (req),
    .ack       (ack),
    .ack_err   (ack_err),
    .grant     (grant),
    .tpu_start (tpu_start),
    .tpu_abort (tpu_abort),
    .tpu_done  (tpu_done),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Job-level model: a job has an owner and an age (0 = start cycle, k = k-th busy cycle).
  bit m_active, m_resp, m_err;
  int m_owner, m_age, m_last, m_count, m_pick;
  logic [3:0] e_ack, e_grant;
  logic e_err, e_start, e_abort, e_busy;

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int got_idx;
  int cnt_before;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < N; i++) begin
      if (v == (4'b0001 << i)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_resp = 1'b0; m_err = 1'b0;
    m_owner = 0; m_age = 0; m_last = N - 1; m_count = 0;
  endtask

  // Every cycle: compare DUT against the model, then advance the model past the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_ack = 4'b0; e_grant = 4'b0; e_err = 1'b0; e_start = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
      if (!srst && m_active) begin
        e_busy = 1'b1;
        if (m_resp) begin
          e_ack = 4'b0001 << m_owner;
          e_err = m_err;
        end else begin
          e_grant = 4'b0001 << m_owner;
          e_start = (m_age == 0);
          e_abort = (m_age == T) && !tpu_done;
        end
      end
      check("m_ack", ack, e_ack);
      check("m_ack_err", ack_err, e_err);
      check("m_grant", grant, e_grant);
      check("m_tpu_start", tpu_start, e_start);
      check("m_tpu_abort", tpu_abort, e_abort);
      check("m_busy", busy, e_busy);
      check("m_job_count", job_count, m_count);

      if (srst) begin
        model_reset();
      end else if (!m_active) begin
        m_pick = rr_pick(req, m_last);
        if (m_pick >= 0) begin
          m_active = 1'b1; m_resp = 1'b0; m_owner = m_pick; m_age = 0;
        end
      end else if (m_resp) begin
        m_last = m_owner;
        if (!m_err && m_count < 65535) m_count++;
        m_active = 1'b0; m_resp = 1'b0;
      end else if (m_age >= 1 && tpu_done) begin
        m_resp = 1'b1; m_err = 1'b0;
      end else if (m_age == T) begin
        m_resp = 1'b1; m_err = 1'b1;
      end else begin
        m_age++;
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic d, input logic s);
    @(posedge clk);
    #1;
    req = r; tpu_done = d; srst = s;
    #1;
  endtask

  task automatic wait_start(input string name, input logic [3:0] r);
    for (int i = 0; i < 8; i++) begin
      cyc(r, 1'b0, 1'b0);
      if (tpu_start) break;
    end
    check(name, tpu_start, 1'b1);
  endtask

  initial begin
    srst = 1'b1; req = 4'b0; tpu_done = 1'b0;
    model_reset();
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", job_count, 16'd0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("rst_grant", grant, 4'b0000);
    check("rst_start", tpu_start, 1'b0);

    // single job, done at cycle 10
    cyc(4'b0001, 1'b0, 1'b0);
    check("s1_c0_start", tpu_start, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    check("s1_start", tpu_start, 1'b1);
    check("s1_grant1", grant, 4'b0001);
    for (int c = 2; c <= 9; c++) cyc(4'b0001, 1'b0, 1'b0);
    check("s1_grant9", grant, 4'b0001);
    cyc(4'b0001, 1'b1, 1'b0);
    check("s1_grant10", grant, 4'b0001);
    cyc(4'b0001, 1'b0, 1'b0);
    check("s1_ack", ack, 4'b0001);
    check("s1_ack_err", ack_err, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("s1_count", job_count, 16'd1);
    check("s1_idle", busy, 1'b0);

    // rotation with all requesting
    cyc(4'b0000, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      wait_start("s2_start_seen", 4'b1111);
      got_idx = oh_idx(grant);
      check("s2_order", got_idx, exp_order[j]);
      for (int k = 1; k <= 4; k++) cyc(4'b1111, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
      check("s2_ack", ack, 4'b0001 << exp_order[j]);
      cyc((j < 4) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
      check("s2_ack_one_cycle", ack, 4'b0000);
    end
    check("s2_count", job_count, 16'd5);

    // timeout abort
    wait_start("s3_start_seen", 4'b0100);
    check("s3_grant", grant, 4'b0100);
    for (int k = 1; k <= T; k++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      if (k == T - 1) check("s3_no_early_abort", tpu_abort, 1'b0);
      if (k == T) check("s3_abort", tpu_abort, 1'b1);
    end
    cyc(4'b0100, 1'b0, 1'b0);
    check("s3_ack", ack, 4'b0100);
    check("s3_ack_err", ack_err, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    check("s3_count", job_count, 16'd5);

    // done coinciding with the last timeout cycle
    wait_start("s4_start_seen", 4'b0100);
    for (int k = 1; k < T; k++) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    check("s4_no_abort", tpu_abort, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    check("s4_ack", ack, 4'b0100);
    check("s4_ack_err", ack_err, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("s4_count", job_count, 16'd6);

    // requester drops req during BUSY, then stray done in IDLE
    wait_start("s5_start_seen", 4'b0010);
    check("s5_grant", grant, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("s5_ack", ack, 4'b0010);
    cnt_before = 7;
    for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b1, 1'b0);
    check("s5_stray_busy", busy, 1'b0);
    check("s5_stray_start", tpu_start, 1'b0);
    check("s5_stray_count", job_count, cnt_before);

    // srst mid-job
    wait_start("s6_start_seen", 4'b1000);
    check("s6_grant", grant, 4'b1000);
    for (int k = 0; k < 3; k++) cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    check("s6_busy", busy, 1'b0);
    check("s6_grant_clr", grant, 4'b0000);
    check("s6_no_ack", ack, 4'b0000);
    check("s6_count", job_count, 16'd0);
    wait_start("s6_restart_seen", 4'b1001);
    check("s6_first_prio", grant, 4'b0001);
    for (int k = 0; k < 3; k++) cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      cyc(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req,
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 299) == 0));
    end

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_job_arbiter.md
TPU_JOB_ARBITER -- requirements
Module: tpu_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one systolic array controller (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum BUSY cycles before a job is aborted (≥16).
REQ-003 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-004 SHALL have srst input 1, synchronous active-high reset.
REQ-005 SHALL have req input NUM_REQ, per-requester job request level, held until matching ack.
REQ-006 SHALL have ack output NUM_REQ, one-hot one-cycle job-complete pulse.
REQ-007 SHALL have ack_err output 1, valid with ack: 1 = job aborted by timeout.
REQ-008 SHALL have grant output NUM_REQ, one-hot owner of the array during START and BUSY, else 0.
REQ-009 SHALL have tpu_start output 1, one-cycle start pulse to the array controller.
REQ-010 SHALL have tpu_abort output 1, one-cycle pulse used to reset the array controller on timeout.
REQ-011 SHALL have tpu_done input 1, one-cycle completion pulse from the array controller.
REQ-012 SHALL have busy output 1, high in any state other than IDLE.
REQ-013 SHALL have job_count output 16, completed-job counter, saturating at 16'hFFFF.

Function
REQ-014 SHALL implement states IDLE, START, BUSY, RESP; all outputs decoded from registered state and registers.
REQ-015 IDLE: if any req bit is set, SHALL latch the round-robin winner into grant_idx and move to START next cycle; otherwise stay.
REQ-016 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward, wrapping; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-017 START: tpu_start=1 for exactly one cycle, then BUSY; BUSY-cycle counter cleared to 0.
REQ-018 Latency: req sampled high in IDLE at cycle t yields tpu_start at t+1 and BUSY at t+2.
REQ-019 BUSY: counter increments each cycle; tpu_done=1 moves to RESP with err flag 0.
REQ-020 BUSY: counter == TIMEOUT_CYCLES-1 without tpu_done SHALL assert tpu_abort that cycle and move to RESP with err flag 1.
REQ-021 tpu_done and timeout in the same cycle: done wins, err 0, no tpu_abort.
REQ-022 RESP: ack[grant_idx]=1 and ack_err=err flag for one cycle; last_grant<=grant_idx; job_count increments only if err=0; return to IDLE.
REQ-023 A requester deasserting req after grant SHALL NOT cancel the job; its ack still pulses.
REQ-024 A requester deasserting req before being granted SHALL be ignored without side effects.
REQ-025 tpu_done in IDLE, START or RESP SHALL be ignored.
REQ-026 Minimum back-to-back job spacing SHALL be one IDLE cycle after RESP, giving a re-arbitration point between jobs.
REQ-027 With all requesters continuously requesting, grants SHALL rotate 0,1,..,NUM_REQ-1,0 with no starvation.

Reset
REQ-028 srst SHALL set state=IDLE, grant_idx=0, last_grant=NUM_REQ-1, counter=0, err=0, job_count=0.
REQ-029 During and after reset, ack, ack_err, grant, tpu_start, tpu_abort and busy SHALL be 0.
REQ-030 srst mid-job SHALL drop the job silently (no ack, no abort pulse); the array controller reset is the system's responsibility.

Structure
REQ-031 Package tpu_sched_pkg SHALL hold the state enum/encoding (2 bits), default NUM_REQ and TIMEOUT_CYCLES, and the counter width function clog2(TIMEOUT_CYCLES).
REQ-032 Sub-module rr_arbiter SHALL be combinational, with inputs req and last_grant and outputs valid and winner index; it is instantiated once.

Verification
REQ-033 Reset, then req=4'b0001 at cycle 0, tpu_done at cycle 10 -> tpu_start at cycle 1, grant=0001 during cycles 1-10, ack=0001 with ack_err=0 at cycle 11, job_count=1.
REQ-034 req=4'b1111 held, tpu_done 5 cycles after each start -> grant order 0,1,2,3,0; each ack is one cycle; job_count=5 after 5 jobs.
REQ-035 req=4'b0100, tpu_done never arrives, TIMEOUT_CYCLES=16 -> tpu_abort in the 16th BUSY cycle, then ack=0100 with ack_err=1, job_count unchanged.
REQ-036 tpu_done coincides with the last timeout cycle -> ack_err=0, no tpu_abort.
REQ-037 Requester 1 drops req during BUSY; stray tpu_done in IDLE -> ack=0010 still pulses; stray tpu_done produces no state change.
REQ-038 srst asserted during BUSY -> next cycle busy=0 and grant=0, no ack; the next req=0001 is granted normally, with requester 0 first.
